// File: rtl/jk_ff_checker.sv
// Run-time checker for a single-bit JK flop: reference model, miscompare pulse,
// saturating error count and sticky fault. Optional toggle counter: JKCHK_TOGGLE_CNT_EN.
module jk_ff_checker #(
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned MAX_ERR = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             chk_en,
    input  logic             j,
    input  logic             k,
    input  logic             q_obs,
    output logic             q_ref,
    output logic             mismatch,
    output logic [CNT_W-1:0] err_cnt,
    output logic             fault,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] tgl_cnt
);

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StTrack = 2'b01,
        StFault = 2'b10
    } state_e;

    localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] MaxErr = CNT_W'(MAX_ERR);

    state_e           state_q, state_d;
    logic             q_ref_q, q_ref_d;
    logic             mismatch_q, mismatch_d;
    logic             fault_q, fault_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic             cmp_en;
    logic             miscmp;

    // Reset overrides every next-state value, so no compare lands on a reset edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            q_ref_q    <= 1'b0;
            mismatch_q <= 1'b0;
            fault_q    <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            q_ref_q    <= q_ref_d;
            mismatch_q <= mismatch_d;
            fault_q    <= fault_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (chk_en) state_d = StTrack;
            StTrack: begin
                if (!chk_en) begin
                    state_d = StIdle;
                end else if (err_cnt_d >= MaxErr) begin
                    state_d = StFault;
                end
            end
            StFault: state_d = StFault;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        q_ref_d = q_ref_q;
        unique case ({j, k})
            2'b00: q_ref_d = q_ref_q;
            2'b01: q_ref_d = 1'b0;
            2'b10: q_ref_d = 1'b1;
            2'b11: q_ref_d = ~q_ref_q;
            default: q_ref_d = q_ref_q;
        endcase

        // q_obs is the flop's pre-edge value, so it is compared with the pre-edge model.
        cmp_en     = chk_en && ((state_q == StTrack) || (state_q == StFault));
        miscmp     = cmp_en && (q_obs != q_ref_q);
        mismatch_d = miscmp;
        err_cnt_d  = err_cnt_q;
        if (miscmp && (err_cnt_q != CntMax)) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
        fault_d = (state_d == StFault);
    end

    assign q_ref    = q_ref_q;
    assign mismatch = mismatch_q;
    assign err_cnt  = err_cnt_q;
    assign fault    = fault_q;
    assign state    = state_q;

`ifdef JKCHK_TOGGLE_CNT_EN
    logic [CNT_W-1:0] tgl_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            tgl_cnt_q <= '0;
        end else if (j && k && (tgl_cnt_q != CntMax)) begin
            tgl_cnt_q <= tgl_cnt_q + 1'b1;
        end
    end

    assign tgl_cnt = tgl_cnt_q;
`else
    assign tgl_cnt = '0;
`endif

endmodule

// File: tb/tb_jk_ff_checker.sv
// Scoreboard bench for jk_ff_checker: directed vectors push expected outputs, a negedge
// monitor pops and compares. DUT a uses defaults, DUT b uses CNT_W=2, MAX_ERR=3.
module tb_jk_ff_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a = 1'b1, chk_a = 1'b0, j_a = 1'b0, k_a = 1'b0, qo_a = 1'b0;
    logic       qr_a, mm_a, flt_a;
    logic [7:0] err_a, tgl_a;
    logic [1:0] st_a;

    logic       rst_b = 1'b1, chk_b = 1'b0, j_b = 1'b0, k_b = 1'b0, qo_b = 1'b0;
    logic       qr_b, mm_b, flt_b;
    logic [1:0] err_b, tgl_b;
    logic [1:0] st_b;

    jk_ff_checker #(.CNT_W(8), .MAX_ERR(4)) dut_a (
        .clk(clk), .rst(rst_a), .chk_en(chk_a), .j(j_a), .k(k_a), .q_obs(qo_a),
        .q_ref(qr_a), .mismatch(mm_a), .err_cnt(err_a), .fault(flt_a), .state(st_a),
        .tgl_cnt(tgl_a)
    );

    jk_ff_checker #(.CNT_W(2), .MAX_ERR(3)) dut_b (
        .clk(clk), .rst(rst_b), .chk_en(chk_b), .j(j_b), .k(k_b), .q_obs(qo_b),
        .q_ref(qr_b), .mismatch(mm_b), .err_cnt(err_b), .fault(flt_b), .state(st_b),
        .tgl_cnt(tgl_b)
    );

    typedef struct {
        bit    which;
        int    q_ref;
        int    mm;
        int    err;
        int    fault;
        int    state;
        int    tgl;
        string name;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   passes = 0;

    function automatic int tg(input int v);
`ifdef JKCHK_TOGGLE_CNT_EN
        return v;
`else
        return 0;
`endif
    endfunction

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            int aq, am, ae, af, as, at;
            e = exp_q.pop_front();
            if (e.which) begin
                aq = int'(qr_b); am = int'(mm_b); ae = int'(err_b);
                af = int'(flt_b); as = int'(st_b); at = int'(tgl_b);
            end else begin
                aq = int'(qr_a); am = int'(mm_a); ae = int'(err_a);
                af = int'(flt_a); as = int'(st_a); at = int'(tgl_a);
            end
            checks++;
            if (aq == e.q_ref && am == e.mm && ae == e.err && af == e.fault &&
                as == e.state && at == e.tgl) begin
                passes++;
            end else begin
                $display("FAIL %s: got q_ref=%0d mm=%0d err=%0d fault=%0d state=%0d tgl=%0d, want q_ref=%0d mm=%0d err=%0d fault=%0d state=%0d tgl=%0d",
                         e.name, aq, am, ae, af, as, at,
                         e.q_ref, e.mm, e.err, e.fault, e.state, e.tgl);
            end
        end
    end

    task automatic step(input bit b, input bit r, input bit c, input bit jj, input bit kk,
                        input bit qo, input int eq, input int em, input int ee, input int ef,
                        input int es, input int et, input string nm);
        exp_t e;
        if (b) begin
            rst_b = r; chk_b = c; j_b = jj; k_b = kk; qo_b = qo;
        end else begin
            rst_a = r; chk_a = c; j_a = jj; k_a = kk; qo_a = qo;
        end
        @(posedge clk);
        e.which = b; e.q_ref = eq; e.mm = em; e.err = ee; e.fault = ef;
        e.state = es; e.tgl = et; e.name = nm;
        exp_q.push_back(e);
        #1;
    endtask

    initial begin
        #1;
        // b  r  c  j  k  qo  q  mm err f  st   tgl
        step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, tg(0), "reset_0");
        step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, tg(0), "reset_1");
        step(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, tg(0), "release_track");
        step(0, 0, 1, 1, 0, 0, 1, 0, 0, 0, 1, tg(0), "good_jk10");
        step(0, 0, 1, 0, 1, 1, 0, 0, 0, 0, 1, tg(0), "good_jk01");
        step(0, 0, 1, 1, 1, 0, 1, 0, 0, 0, 1, tg(1), "good_jk11_a");
        step(0, 0, 1, 1, 1, 1, 0, 0, 0, 0, 1, tg(2), "good_jk11_b");
        step(0, 0, 1, 1, 1, 0, 1, 0, 0, 0, 1, tg(3), "good_jk11_c");
        step(0, 0, 1, 0, 0, 1, 1, 0, 0, 0, 1, tg(3), "good_jk00");
        step(0, 0, 1, 0, 0, 0, 1, 1, 1, 0, 1, tg(3), "single_fault");
        step(0, 0, 1, 0, 0, 1, 1, 0, 1, 0, 1, tg(3), "single_fault_end");
        step(0, 0, 1, 1, 1, 0, 0, 1, 2, 0, 1, tg(4), "esc_1");
        step(0, 0, 1, 1, 1, 0, 1, 0, 2, 0, 1, tg(5), "esc_2");
        step(0, 0, 1, 1, 1, 0, 0, 1, 3, 0, 1, tg(6), "esc_3");
        step(0, 0, 1, 1, 1, 0, 1, 0, 3, 0, 1, tg(7), "esc_4");
        step(0, 0, 1, 1, 1, 0, 0, 1, 4, 1, 2, tg(8), "esc_fault");
        step(0, 0, 0, 0, 0, 0, 0, 0, 4, 1, 2, tg(8), "fault_sticky_0");
        step(0, 0, 0, 0, 0, 0, 0, 0, 4, 1, 2, tg(8), "fault_sticky_1");
        step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, tg(0), "fault_reset");
        step(0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0, tg(1), "gate_0");
        step(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, tg(2), "gate_1");
        step(0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0, tg(3), "gate_2");
        step(0, 0, 1, 0, 0, 1, 1, 0, 0, 0, 1, tg(3), "reenable");
        step(0, 0, 1, 0, 0, 1, 1, 0, 0, 0, 1, tg(3), "reenable_cmp");
        step(0, 0, 1, 0, 1, 1, 0, 0, 0, 0, 1, tg(3), "reenable_jk01");
        step(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, tg(3), "track_to_idle");
        step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, tg(0), "a_park_reset");
        // Saturation / toggle counting on the narrow instance.
        step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, tg(0), "b_reset");
        step(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, tg(0), "b_track");
        step(1, 0, 1, 0, 0, 1, 0, 1, 1, 0, 1, tg(0), "b_mis_1");
        step(1, 0, 1, 0, 0, 1, 0, 1, 2, 0, 1, tg(0), "b_mis_2");
        step(1, 0, 1, 0, 0, 1, 0, 1, 3, 1, 2, tg(0), "b_mis_3_fault");
        step(1, 0, 1, 0, 0, 1, 0, 1, 3, 1, 2, tg(0), "b_mis_4_sat");
        step(1, 0, 1, 0, 0, 1, 0, 1, 3, 1, 2, tg(0), "b_mis_5_sat");
        step(1, 0, 1, 0, 0, 1, 0, 1, 3, 1, 2, tg(0), "b_mis_6_sat");
        step(1, 0, 1, 1, 1, 0, 1, 0, 3, 1, 2, tg(1), "b_tgl_1");
        step(1, 0, 1, 1, 1, 1, 0, 0, 3, 1, 2, tg(2), "b_tgl_2");
        step(1, 0, 1, 1, 1, 0, 1, 0, 3, 1, 2, tg(3), "b_tgl_3");
        step(1, 0, 1, 1, 1, 1, 0, 0, 3, 1, 2, tg(3), "b_tgl_4_sat");
        step(1, 0, 1, 1, 1, 0, 1, 0, 3, 1, 2, tg(3), "b_tgl_5_sat");
        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() == 0) begin
            passes++;
        end else begin
            $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
